// File: rtl/sbus_pkg.sv
// Shared SBUS definitions: control-byte bit positions and the egress write FSM states.
package sbus_pkg;
  localparam int unsigned SBUS_CTL_WIDTH = 8;
  localparam int unsigned SBUS_CTL_SOP   = 0;
  localparam int unsigned SBUS_CTL_EOP   = 1;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_PASS,
    WR_DROP
  } wr_state_e;
endpackage

// File: rtl/sbus2axis_pkt_fifo.sv
// Store-and-forward packet FIFO: data becomes readable only once committed; the
// uncommitted tail can be rewound without touching committed entries or the read side.
module sbus2axis_pkt_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic             i_wr_restart,
  input  logic             i_commit,
  input  logic             i_rewind,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_commit_full,
  output logic             o_readable
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_commit_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    w_wr_addr;
  logic [PW-1:0]    w_wr_next;

  // A restarted packet overwrites the abandoned tail, starting at the commit point.
  assign w_wr_addr     = i_wr_restart ? r_commit_ptr : r_wr_ptr;
  assign w_wr_next     = w_wr_addr + PW'(1);
  assign o_full        = (r_wr_ptr - r_rd_ptr) == PW'(DEPTH);
  assign o_commit_full = (r_commit_ptr - r_rd_ptr) == PW'(DEPTH);
  assign o_readable    = r_rd_ptr != r_commit_ptr;
  assign o_rd_data     = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[w_wr_addr[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
    end else begin
      if (i_rewind) begin
        r_wr_ptr <= r_commit_ptr;
      end else if (i_wr_en) begin
        r_wr_ptr <= w_wr_next;
        if (i_commit) r_commit_ptr <= w_wr_next;
      end
      if (i_rd_en && o_readable) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end
endmodule

// File: rtl/sbus2axis.sv
// SBUS to AXI4-Stream egress: buffers whole packets, drops overflowing or malformed
// ones atomically, and streams committed beats through a one-entry output register.
module sbus2axis
  import sbus_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 256,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      S_SBUS_VALID,
  input  logic [TDATA_WIDTH-1:0]    S_SBUS_TDATA,
  input  logic [TDATA_WIDTH/8-1:0]  S_SBUS_TKEEP,
  input  logic [SBUS_CTL_WIDTH-1:0] S_SBUS_CTL,
  output logic                      M_AXIS_TVALID,
  output logic [TDATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [TDATA_WIDTH/8-1:0]  M_AXIS_TKEEP,
  output logic                      M_AXIS_TLAST,
  input  logic                      M_AXIS_TREADY,
  output logic [CNT_WIDTH-1:0]      DROP_COUNT,
  output logic                      DROP_PULSE
);
  localparam int unsigned KW = TDATA_WIDTH / 8;
  localparam int unsigned EW = TDATA_WIDTH + KW + 1;

  wr_state_e        r_state, w_next;
  logic             w_sop, w_eop, w_unused_ctl;
  logic             w_wr_en, w_restart, w_commit, w_rewind;
  logic [1:0]       w_drop_n;
  logic             w_full, w_commit_full, w_readable, w_rd_en;
  logic [EW-1:0]    w_rd_data;
  logic                   r_tvalid, r_tlast, r_drop_pulse;
  logic [TDATA_WIDTH-1:0] r_tdata;
  logic [KW-1:0]          r_tkeep;
  logic [CNT_WIDTH-1:0]   r_drop_count;

  assign w_sop        = S_SBUS_CTL[SBUS_CTL_SOP];
  assign w_eop        = S_SBUS_CTL[SBUS_CTL_EOP];
  assign w_unused_ctl = &S_SBUS_CTL;

  sbus2axis_pkt_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk         (ACLK),
    .i_rst         (ARESET),
    .i_wr_en       (w_wr_en),
    .i_wr_restart  (w_restart),
    .i_commit      (w_commit),
    .i_rewind      (w_rewind),
    .i_wr_data     ({w_eop, S_SBUS_TKEEP, S_SBUS_TDATA}),
    .i_rd_en       (w_rd_en),
    .o_rd_data     (w_rd_data),
    .o_full        (w_full),
    .o_commit_full (w_commit_full),
    .o_readable    (w_readable)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= WR_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_wr_en   = 1'b0;
    w_restart = 1'b0;
    w_commit  = 1'b0;
    w_rewind  = 1'b0;
    w_drop_n  = 2'd0;
    if (S_SBUS_VALID) begin
      case (r_state)
        WR_PASS: begin
          // SOP mid-packet abandons the old packet; if even the committed region is
          // full, the new packet is lost as well and both are counted.
          if (w_sop) begin
            if (w_commit_full) begin
              w_drop_n = 2'd2;
              w_rewind = 1'b1;
              w_next   = w_eop ? WR_IDLE : WR_DROP;
            end else begin
              w_drop_n  = 2'd1;
              w_wr_en   = 1'b1;
              w_restart = 1'b1;
              w_commit  = w_eop;
              w_next    = w_eop ? WR_IDLE : WR_PASS;
            end
          end else if (w_full) begin
            w_drop_n = 2'd1;
            w_rewind = 1'b1;
            w_next   = w_eop ? WR_IDLE : WR_DROP;
          end else begin
            w_wr_en  = 1'b1;
            w_commit = w_eop;
            if (w_eop) w_next = WR_IDLE;
          end
        end
        default: begin
          if (w_sop) begin
            if (w_full) begin
              w_drop_n = 2'd1;
              w_rewind = 1'b1;
              w_next   = w_eop ? WR_IDLE : WR_DROP;
            end else begin
              w_wr_en  = 1'b1;
              w_commit = w_eop;
              w_next   = w_eop ? WR_IDLE : WR_PASS;
            end
          end else if (w_eop) begin
            w_next = WR_IDLE;
          end
        end
      endcase
    end
  end

  assign w_rd_en = w_readable && (!r_tvalid || M_AXIS_TREADY);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
    end else if (w_rd_en) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_rd_data[TDATA_WIDTH-1:0];
      r_tkeep  <= w_rd_data[TDATA_WIDTH +: KW];
      r_tlast  <= w_rd_data[EW-1];
    end else if (M_AXIS_TREADY) begin
      r_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_drop_count <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_count <= r_drop_count + CNT_WIDTH'(w_drop_n);
      r_drop_pulse <= w_drop_n != 2'd0;
    end
  end

  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TKEEP  = r_tkeep;
  assign M_AXIS_TLAST  = r_tlast;
  assign DROP_COUNT    = r_drop_count;
  assign DROP_PULSE    = r_drop_pulse;
endmodule

// File: tb/tb_sbus2axis.sv
// Directed bench for sbus2axis: latency, streaming, overflow, malformed, oversize and reset cases.
module tb_sbus2axis;
  localparam int unsigned DW = 256, KW = 32, DEPTH = 64, CW = 32;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [KW-1:0] s_keep = '0;
  logic [7:0]    s_ctl = '0;
  logic          tvalid, tlast, tready = 1'b0, dpulse;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic [CW-1:0] dcount;

  always #5 clk = ~clk;

  sbus2axis #(.TDATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .ACLK(clk), .ARESET(arst),
    .S_SBUS_VALID(s_valid), .S_SBUS_TDATA(s_data), .S_SBUS_TKEEP(s_keep), .S_SBUS_CTL(s_ctl),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TKEEP(tkeep), .M_AXIS_TLAST(tlast),
    .M_AXIS_TREADY(tready), .DROP_COUNT(dcount), .DROP_PULSE(dpulse)
  );

  int total = 0, bad = 0, cyc = 0, pulses = 0;
  logic [DW-1:0] q_data[$];
  logic [KW-1:0] q_keep[$];
  logic          q_last[$];
  int            q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!arst && tvalid && tready) begin
      q_data.push_back(tdata);
      q_keep.push_back(tkeep);
      q_last.push_back(tlast);
      q_cyc.push_back(cyc);
    end
    if (dpulse) pulses++;
  end

  function automatic logic [DW-1:0] mk(input int p, input int b);
    return {8{p[15:0], b[15:0]}};
  endfunction

  task automatic beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic sop, input logic eop);
    s_valid = 1'b1; s_data = d; s_keep = k; s_ctl = {6'b0, eop, sop};
    @(posedge clk); #1;
    s_valid = 1'b0; s_ctl = '0;
  endtask

  task automatic send_pkt(input int p, input int n, input logic [KW-1:0] k);
    for (int b = 0; b < n; b++) beat(mk(p, b), k, b == 0, b == n - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    q_data.delete(); q_keep.delete(); q_last.delete(); q_cyc.delete();
  endtask

  task automatic test_reset();
    arst = 1'b1; tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
    total++; if (tdata !== '0) begin bad++; $display("FAIL reset_tdata: got %h want 0", tdata); end
    total++; if (tkeep !== '0) begin bad++; $display("FAIL reset_tkeep: got %h want 0", tkeep); end
    total++; if (tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %b want 0", tlast); end
    total++; if (dpulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b want 0", dpulse); end
    total++; if (dcount !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", dcount); end
    arst = 1'b0;
    idle(1);
  endtask

  task automatic test_single();
    tready = 1'b1; clear_rx();
    beat(mk(1, 0), 32'h0000_00FF, 1'b1, 1'b1);
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL single_early: got tvalid %b want 0", tvalid); end
    idle(1);
    total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL single_latency: got tvalid %b want 1", tvalid); end
    total++; if (tdata !== mk(1, 0)) begin bad++; $display("FAIL single_data: got %h want %h", tdata, mk(1, 0)); end
    total++; if (tkeep !== 32'h0000_00FF) begin bad++; $display("FAIL single_keep: got %h want 000000ff", tkeep); end
    total++; if (tlast !== 1'b1) begin bad++; $display("FAIL single_last: got %b want 1", tlast); end
    idle(4);
    total++; if (q_data.size() != 1) begin bad++; $display("FAIL single_count: got %0d beats want 1", q_data.size()); end
    total++; if (dcount !== 32'd0) begin bad++; $display("FAIL single_drops: got %0d want 0", dcount); end
  endtask

  task automatic test_back_to_back();
    tready = 1'b1; clear_rx();
    for (int p = 2; p <= 4; p++) send_pkt(p, 4, '1);
    idle(10);
    total++; if (q_data.size() != 12) begin bad++; $display("FAIL b2b_count: got %0d beats want 12", q_data.size()); end
    for (int i = 0; i < 12; i++) begin
      if (i >= q_data.size()) break;
      total++; if (q_data[i] !== mk(2 + i / 4, i % 4)) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, q_data[i], mk(2 + i / 4, i % 4)); end
      total++; if (q_last[i] !== (i % 4 == 3)) begin bad++; $display("FAIL b2b_last[%0d]: got %b want %b", i, q_last[i], (i % 4 == 3)); end
      total++; if (q_cyc[i] != q_cyc[0] + i) begin bad++; $display("FAIL b2b_bubble[%0d]: got cycle %0d want %0d", i, q_cyc[i], q_cyc[0] + i); end
    end
  endtask

  task automatic test_overflow();
    tready = 1'b0; clear_rx(); pulses = 0;
    send_pkt(10, 48, 32'h0000_FFFF);
    send_pkt(11, 32, 32'h0000_FFFF);
    idle(3);
    total++; if (dcount !== 32'd1) begin bad++; $display("FAIL ovf_count: got %0d want 1", dcount); end
    total++; if (pulses != 1) begin bad++; $display("FAIL ovf_pulses: got %0d want 1", pulses); end
    total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL ovf_hold_valid: got %b want 1", tvalid); end
    total++; if (tdata !== mk(10, 0)) begin bad++; $display("FAIL ovf_hold_data: got %h want %h", tdata, mk(10, 0)); end
    idle(2);
    total++; if (tdata !== mk(10, 0) || tlast !== 1'b0) begin bad++; $display("FAIL ovf_stable: got %h/%b want %h/0", tdata, tlast, mk(10, 0)); end
    total++; if (q_data.size() != 0) begin bad++; $display("FAIL ovf_stall: got %0d beats want 0", q_data.size()); end
    tready = 1'b1;
    idle(60);
    total++; if (q_data.size() != 48) begin bad++; $display("FAIL ovf_beats: got %0d want 48", q_data.size()); end
    for (int i = 0; i < 48; i++) begin
      if (i >= q_data.size()) break;
      total++; if (q_data[i] !== mk(10, i) || q_last[i] !== (i == 47)) begin bad++; $display("FAIL ovf_beat[%0d]: got %h/%b want %h/%b", i, q_data[i], q_last[i], mk(10, i), (i == 47)); end
    end
  endtask

  task automatic test_malformed();
    tready = 1'b1; clear_rx(); pulses = 0;
    beat(mk(20, 0), 32'hF, 1'b1, 1'b0);
    beat(mk(20, 1), 32'hF, 1'b0, 1'b0);
    beat(mk(20, 2), 32'hF, 1'b0, 1'b0);
    beat(mk(21, 0), 32'h3, 1'b1, 1'b0);
    total++; if (dpulse !== 1'b1) begin bad++; $display("FAIL mal_pulse: got %b want 1", dpulse); end
    beat(mk(21, 1), 32'h3, 1'b0, 1'b0);
    total++; if (dpulse !== 1'b0) begin bad++; $display("FAIL mal_pulse_end: got %b want 0", dpulse); end
    beat(mk(21, 2), 32'h3, 1'b0, 1'b1);
    idle(6);
    total++; if (q_data.size() != 3) begin bad++; $display("FAIL mal_count: got %0d beats want 3", q_data.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i >= q_data.size()) break;
      total++; if (q_data[i] !== mk(21, i) || q_keep[i] !== 32'h3 || q_last[i] !== (i == 2)) begin bad++; $display("FAIL mal_beat[%0d]: got %h/%h/%b want %h/3/%b", i, q_data[i], q_keep[i], q_last[i], mk(21, i), (i == 2)); end
    end
    total++; if (dcount !== 32'd2) begin bad++; $display("FAIL mal_drops: got %0d want 2", dcount); end
  endtask

  task automatic test_long();
    tready = 1'b1; clear_rx();
    send_pkt(30, 70, '1);
    idle(4);
    total++; if (q_data.size() != 0) begin bad++; $display("FAIL long_out: got %0d beats want 0", q_data.size()); end
    total++; if (dcount !== 32'd3) begin bad++; $display("FAIL long_drops: got %0d want 3", dcount); end
    send_pkt(31, 1, 32'hFF);
    idle(4);
    total++; if (q_data.size() != 1) begin bad++; $display("FAIL long_next_count: got %0d want 1", q_data.size()); end
    else begin
      total++; if (q_data[0] !== mk(31, 0) || q_last[0] !== 1'b1) begin bad++; $display("FAIL long_next_beat: got %h/%b want %h/1", q_data[0], q_last[0], mk(31, 0)); end
    end
  endtask

  task automatic test_reset_mid();
    tready = 1'b0; clear_rx();
    send_pkt(40, 4, '1);
    beat(mk(41, 0), '1, 1'b1, 1'b0);
    beat(mk(41, 1), '1, 1'b0, 1'b0);
    total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid: got %b want 1", tvalid); end
    arst = 1'b1;
    idle(1);
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", tvalid); end
    total++; if (dcount !== 32'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", dcount); end
    total++; if (tdata !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", tdata); end
    arst = 1'b0;
    idle(1);
    tready = 1'b1; clear_rx();
    send_pkt(42, 2, 32'hABCD);
    idle(6);
    total++; if (q_data.size() != 2) begin bad++; $display("FAIL rst_after_count: got %0d want 2", q_data.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i >= q_data.size()) break;
      total++; if (q_data[i] !== mk(42, i) || q_keep[i] !== 32'hABCD || q_last[i] !== (i == 1)) begin bad++; $display("FAIL rst_after_beat[%0d]: got %h/%h/%b want %h/abcd/%b", i, q_data[i], q_keep[i], q_last[i], mk(42, i), (i == 1)); end
    end
    total++; if (dcount !== 32'd0) begin bad++; $display("FAIL rst_after_drops: got %0d want 0", dcount); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_malformed();
    test_long();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
